// File: rtl/fifo_burst_drain.sv
// Drains an 8-bit FIFO (1-cycle read latency) into a valid/ready byte stream.
// It sends full BURST_LEN packets, or a short packet after an idle timeout.
module fifo_burst_drain #(
  parameter int DATA_W    = 8,
  parameter int COUNT_W   = 9,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               srst,
  input  logic [DATA_W-1:0]  fifo_dout,
  input  logic               fifo_empty,
  input  logic [COUNT_W-1:0] fifo_data_count,
  output logic               fifo_rd_en,
  output logic [DATA_W-1:0]  m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               busy
);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [COUNT_W-1:0] BLEN = COUNT_W'(BURST_LEN);
  localparam logic [TW-1:0]      TMAX = TW'(TIMEOUT);

  typedef enum logic {IDLE, BURST} state_e;

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] pkt_len_q, pkt_len_d;
  logic [COUNT_W-1:0] issued_q, issued_d;
  logic [COUNT_W-1:0] sent_q, sent_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               inflight_q;
  logic [DATA_W-1:0]  skid_q [4];
  logic [1:0]         wr_ptr_q, rd_ptr_q;
  logic [2:0]         occ_q;
  logic               push, pop, room;

  assign push     = inflight_q;
  assign m_tvalid = (occ_q != 3'd0);
  assign pop      = m_tvalid & m_tready;
  assign m_tdata  = m_tvalid ? skid_q[rd_ptr_q] : '0;
  assign m_tlast  = m_tvalid & (sent_q == pkt_len_q - COUNT_W'(1));
  assign busy     = (state_q == BURST);
  // A read is only issued if its byte is guaranteed a skid slot on arrival.
  assign room     = (occ_q + {2'b00, inflight_q}) <= 3'd2;

  always_comb begin
    state_d    = state_q;
    pkt_len_d  = pkt_len_q;
    issued_d   = issued_q;
    sent_d     = sent_q;
    timer_d    = timer_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        issued_d = '0;
        sent_d   = '0;
        if (fifo_data_count >= BLEN) begin
          pkt_len_d = BLEN;
          state_d   = BURST;
          timer_d   = '0;
        end else if (TIMEOUT != 0 && timer_q == TMAX && fifo_data_count != '0) begin
          pkt_len_d = fifo_data_count;
          state_d   = BURST;
          timer_d   = '0;
        end else if (fifo_empty) begin
          timer_d = '0;
        end else if (timer_q != TMAX) begin
          timer_d = timer_q + TW'(1);
        end
      end
      BURST: begin
        timer_d    = '0;
        fifo_rd_en = !fifo_empty && (issued_q < pkt_len_q) && room && !srst;
        if (fifo_rd_en) issued_d = issued_q + COUNT_W'(1);
        if (pop)        sent_d   = sent_q + COUNT_W'(1);
        if (pop && m_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= IDLE;
      pkt_len_q  <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      timer_q    <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      pkt_len_q  <= pkt_len_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      timer_q    <= timer_d;
      inflight_q <= fifo_rd_en;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 3'd1;
        2'b01:   occ_q <= occ_q - 3'd1;
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset; m_tdata is gated by m_tvalid.
  always_ff @(posedge clk) begin
    if (push) skid_q[wr_ptr_q] <= fifo_dout;
  end
endmodule

// File: tb/tb_fifo_burst_drain.sv
// Directed bench for fifo_burst_drain: a queue-based FIFO model feeds the DUT.
// A byte/packet scoreboard plus per-cycle stream-rule checks judge the output.
module tb_fifo_burst_drain;
  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst = 1'b1;
  logic [7:0] fifo_dout = '0;
  logic       fifo_empty = 1'b1;
  logic [8:0] fifo_data_count = '0;
  logic       fifo_rd_en, m_tvalid, m_tlast, busy;
  logic [7:0] m_tdata;
  logic       m_tready = 1'b0;

  fifo_burst_drain #(.DATA_W(8), .COUNT_W(9), .BURST_LEN(16), .TIMEOUT(20)) dut (
    .clk(clk), .srst(srst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_data_count(fifo_data_count), .fifo_rd_en(fifo_rd_en), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy)
  );

  // Upstream FIFO model: standard read mode, dout valid the cycle after rd_en.
  logic [7:0] fq[$];
  int         wr_cnt = 0;
  logic [7:0] wr_base = '0;
  logic       flush = 1'b0;
  logic       rd_s = 1'b0;

  always @(negedge clk) rd_s = fifo_rd_en;

  always @(posedge clk) begin
    if (flush) fq.delete();
    else begin
      if (rd_s && fq.size() > 0) fifo_dout <= fq.pop_front();
      for (int i = 0; i < wr_cnt; i++) fq.push_back(wr_base + 8'(i));
    end
    fifo_data_count <= 9'(fq.size());
    fifo_empty      <= (fq.size() == 0);
  end

  // Scoreboard and bookkeeping, owned by the stimulus process.
  int         n_tests = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  int         plen_q[$];
  int         pos = 0, pkts = 0, cyc = 0, outst = 0, n_hs = 0;
  int         first_rd, last_rd, n_rd, first_vld, last_vld, n_vld, first_ne;
  logic       prev_stall = 1'b0, prev_last = 1'b0, tog = 1'b0;
  logic [7:0] prev_data = '0, s_data = '0;
  logic       s_rd = 1'b0, s_vld = 1'b0, s_last = 1'b0, s_busy = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clr_stats();
    first_rd = -1; last_rd = -1; n_rd = 0;
    first_vld = -1; last_vld = -1; n_vld = 0;
    first_ne = -1; pkts = 0; n_hs = 0;
  endtask

  // One clock: sample mid-cycle, check, then return just after the next edge.
  task automatic tick();
    logic hs;
    @(negedge clk);
    cyc++;
    s_rd = fifo_rd_en; s_vld = m_tvalid; s_last = m_tlast; s_busy = busy; s_data = m_tdata;
    hs = m_tvalid && m_tready && !srst;
    chk("rd_guard", int'(fifo_rd_en && (fifo_empty || srst)), 0);
    chk("occ_bound", int'(outst > 4), 0);
    if (prev_stall && !srst) begin
      chk("stall_vld", int'(m_tvalid), 1);
      chk("stall_data", int'(m_tdata), int'(prev_data));
      chk("stall_last", int'(m_tlast), int'(prev_last));
    end
    if (fifo_rd_en || m_tvalid) chk("busy_active", int'(busy), 1);
    if (hs) begin
      n_hs++;
      if (exp_q.size() == 0) chk("extra_byte", 1, 0);
      else chk("data", int'(m_tdata), int'(exp_q.pop_front()));
      if (plen_q.size() == 0) chk("unexpected_pkt", 1, 0);
      else begin
        chk("tlast", int'(m_tlast), int'(pos == plen_q[0] - 1));
        if (pos == plen_q[0] - 1) begin
          void'(plen_q.pop_front());
          pos = 0;
          pkts++;
        end else pos++;
      end
    end
    if (fifo_rd_en) begin
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc; n_rd++;
    end
    if (m_tvalid) begin
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc; n_vld++;
    end
    if (!fifo_empty && first_ne < 0) first_ne = cyc;
    prev_stall = m_tvalid && !m_tready && !srst;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    if (srst) begin
      outst = 0; exp_q.delete(); plen_q.delete(); pos = 0;
    end else outst += int'(fifo_rd_en) - int'(hs);
    @(posedge clk);
    #1;
    if (tog) m_tready = ~m_tready;
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 8'(i));
    wr_cnt = n; wr_base = base;
    tick();
    wr_cnt = 0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0 || plen_q.size() != 0) && k < 600) begin
      tick();
      k++;
    end
    chk({name, "_timeout"}, int'(k >= 600), 0);
    tick();
    chk({name, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int k;
    clr_stats();
    // T1: reset held with a non-empty FIFO
    wr_cnt = 20; wr_base = 8'hA0;
    tick();
    wr_cnt = 0;
    repeat (3) begin
      tick();
      chk("t1_rd", int'(s_rd), 0);
      chk("t1_vld", int'(s_vld), 0);
      chk("t1_last", int'(s_last), 0);
      chk("t1_busy", int'(s_busy), 0);
      chk("t1_data", int'(s_data), 0);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0; srst = 1'b0;
    tick();

    // T2: full burst with sink always ready
    clr_stats(); m_tready = 1'b1;
    plen_q.push_back(16);
    load(16, 8'h00);
    wait_idle("t2");
    chk("t2_rd_cnt", n_rd, 16);
    chk("t2_rd_span", last_rd - first_rd, 15);
    chk("t2_latency", first_vld - first_rd, 2);
    chk("t2_vld_cnt", n_vld, 16);
    chk("t2_vld_span", last_vld - first_vld, 15);
    chk("t2_pkts", pkts, 1);

    // T3: 32 bytes with toggling ready
    clr_stats();
    plen_q.push_back(16); plen_q.push_back(16);
    tog = 1'b1;
    load(32, 8'h20);
    wait_idle("t3");
    tog = 1'b0; m_tready = 1'b1;
    chk("t3_pkts", pkts, 2);
    chk("t3_bytes", n_hs, 32);

    // T4: short packet flushed by timeout
    clr_stats();
    plen_q.push_back(5);
    load(5, 8'h60);
    wait_idle("t4");
    chk("t4_start", first_rd - first_ne, 21);
    chk("t4_pkts", pkts, 1);
    chk("t4_rd_cnt", n_rd, 5);

    // T5: 40 bytes trickled in one per cycle
    clr_stats();
    plen_q.push_back(16); plen_q.push_back(16); plen_q.push_back(8);
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(8'h40 + 8'(i));
      wr_cnt = 1; wr_base = 8'h40 + 8'(i);
      tick();
    end
    wr_cnt = 0;
    wait_idle("t5");
    chk("t5_pkts", pkts, 3);
    chk("t5_bytes", n_hs, 40);

    // T6: reset in the middle of a packet, then a clean packet
    clr_stats();
    plen_q.push_back(16);
    load(16, 8'h90);
    k = 0;
    while (n_hs < 7 && k < 100) begin
      tick();
      k++;
    end
    chk("t6_wait_timeout", int'(k >= 100), 0);
    srst = 1'b1; flush = 1'b1; m_tready = 1'b0;
    tick();
    chk("t6_rd_in_srst", int'(s_rd), 0);
    srst = 1'b0; flush = 1'b0; m_tready = 1'b1;
    tick();
    chk("t6_vld_after", int'(s_vld), 0);
    clr_stats();
    plen_q.push_back(16);
    load(16, 8'hC0);
    wait_idle("t6");
    chk("t6_pkts", pkts, 1);
    chk("t6_bytes", n_hs, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule
